condlogic: RTL and testbench

CONDLOGIC -- requirements
Module: condlogic

---
 rtl/arm_pkg.sv | 41 ++++
 rtl/condcheck.sv | 52 +++++
 rtl/condlogic.sv | 107 ++++++++++
 tb/tb_condlogic.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Condition codes, flag bit positions and tracker state type
//               shared by the conditional-execution logic.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    // Instruction condition field encodings (Instr[31:28])
    localparam logic [3:0] c_cond_eq = 4'b0000;
    localparam logic [3:0] c_cond_ne = 4'b0001;
    localparam logic [3:0] c_cond_cs = 4'b0010;
    localparam logic [3:0] c_cond_cc = 4'b0011;
    localparam logic [3:0] c_cond_mi = 4'b0100;
    localparam logic [3:0] c_cond_pl = 4'b0101;
    localparam logic [3:0] c_cond_vs = 4'b0110;
    localparam logic [3:0] c_cond_vc = 4'b0111;
    localparam logic [3:0] c_cond_hi = 4'b1000;
    localparam logic [3:0] c_cond_ls = 4'b1001;
    localparam logic [3:0] c_cond_ge = 4'b1010;
    localparam logic [3:0] c_cond_lt = 4'b1011;
    localparam logic [3:0] c_cond_gt = 4'b1100;
    localparam logic [3:0] c_cond_le = 4'b1101;
    localparam logic [3:0] c_cond_al = 4'b1110;
    localparam logic [3:0] c_cond_nv = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    // Per-instruction tracker: waiting for a fetch, or decoding the new one
    typedef enum logic [0:0] {
        WAIT_IR = 1'b0,
        EVAL    = 1'b1
    } cl_state_t;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/condcheck.sv
`default_nettype none
// ============================================================================
// Module      : condcheck
// Description : Combinational evaluation of an instruction condition field
//               against the architectural {N,Z,C,V} flags.
// Revision    : 1.0 - initial release
// ============================================================================
module condcheck
    import arm_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = Flags[c_flag_n];
    assign w_z  = Flags[c_flag_z];
    assign w_c  = Flags[c_flag_c];
    assign w_v  = Flags[c_flag_v];
    assign w_ge = (w_n == w_v);

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            c_cond_eq: CondEx = w_z;
            c_cond_ne: CondEx = ~w_z;
            c_cond_cs: CondEx = w_c;
            c_cond_cc: CondEx = ~w_c;
            c_cond_mi: CondEx = w_n;
            c_cond_pl: CondEx = ~w_n;
            c_cond_vs: CondEx = w_v;
            c_cond_vc: CondEx = ~w_v;
            c_cond_hi: CondEx = w_c & ~w_z;
            c_cond_ls: CondEx = ~w_c | w_z;
            c_cond_ge: CondEx = w_ge;
            c_cond_lt: CondEx = ~w_ge;
            c_cond_gt: CondEx = ~w_z & w_ge;
            c_cond_le: CondEx = w_z | ~w_ge;
            c_cond_al: CondEx = 1'b1;
            c_cond_nv: CondEx = 1'b0;
            default:   CondEx = 1'b0;
        endcase
    end

endmodule : condcheck
`default_nettype wire

// File: rtl/condlogic.sv
`default_nettype none
// ============================================================================
// Module      : condlogic
// Description : Conditional-execution control for a multicycle ARM core:
//               flag register, per-instruction CondEx latch and write gating.
// Revision    : 1.0 - initial release
// ============================================================================
module condlogic
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    cl_state_t  r_state;
    cl_state_t  w_state_next;
    logic       r_condex;
    logic [3:0] r_flags;
    logic       w_cond_pass;
    logic       w_capture;
    logic       w_wr_nz;
    logic       w_wr_cv;

    // Condition is checked against the registered flags only, so an ALU
    // result produced in the same cycle can never influence it.
    condcheck u_condcheck (
        .Cond   (Cond),
        .Flags  (r_flags),
        .CondEx (w_cond_pass)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_IR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            WAIT_IR: begin
                if (IRWrite) begin
                    w_state_next = EVAL;
                end
            end
            EVAL: begin
                w_capture    = 1'b1;
                w_state_next = IRWrite ? EVAL : WAIT_IR;
            end
            default: begin
                w_state_next = WAIT_IR;
            end
        endcase
    end

    // CondEx is frozen between decode edges so flag writes made by the
    // instruction itself cannot retroactively cancel its own writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_condex <= 1'b0;
        end else if (w_capture) begin
            r_condex <= w_cond_pass;
        end
    end

    assign w_wr_nz = FlagW[1] & r_condex & (r_state == WAIT_IR);
    assign w_wr_cv = FlagW[0] & r_condex & (r_state == WAIT_IR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_wr_nz) begin
                r_flags[c_flag_n] <= ALUFlags[c_flag_n];
                r_flags[c_flag_z] <= ALUFlags[c_flag_z];
            end
            if (w_wr_cv) begin
                r_flags[c_flag_c] <= ALUFlags[c_flag_c];
                r_flags[c_flag_v] <= ALUFlags[c_flag_v];
            end
        end
    end

    assign PCWrite  = NextPC | (PCS & r_condex);
    assign RegWrite = RegW & r_condex;
    assign MemWrite = MemW & r_condex;
    assign Flags    = r_flags;
    assign CondEx   = r_condex;

endmodule : condlogic
`default_nettype wire

// File: tb/tb_condlogic.sv
`default_nettype none
// ============================================================================
// Module      : tb_condlogic
// Description : Directed self-checking bench for condlogic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_condlogic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondEx;

    int vectors;
    int miscompares;

    condlogic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondEx   (CondEx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ALUFlags = 4'b0000;
        FlagW    = 2'b00;
        PCS      = 1'b0;
        NextPC   = 1'b0;
        RegW     = 1'b0;
        MemW     = 1'b0;
        IRWrite  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Fetch cycle then decode cycle; returns just after the capture edge.
    task automatic fetch(input logic [3:0] c);
        Cond    = c;
        IRWrite = 1'b1;
        NextPC  = 1'b1;
        tick();
        IRWrite = 1'b0;
        NextPC  = 1'b0;
        tick();
    endtask

    // Run an AL instruction that writes all four flags.
    task automatic set_flags(input logic [3:0] f);
        fetch(4'b1110);
        FlagW    = 2'b11;
        ALUFlags = f;
        tick();
        FlagW    = 2'b00;
        ALUFlags = 4'b0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        Cond   = 4'b1110;
        reset  = 1'b1;
        NextPC = 1'b1;
        RegW   = 1'b1;
        MemW   = 1'b1;
        PCS    = 1'b1;
        #1;
        vectors++;
        if (Flags !== 4'b0000) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 0000", Flags);
        end
        vectors++;
        if (CondEx !== 1'b0) begin
            miscompares++; $display("FAIL reset_condex: got %b expected 0", CondEx);
        end
        vectors++;
        if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            miscompares++; $display("FAIL reset_gating: got RegWrite=%b MemWrite=%b expected 0/0", RegWrite, MemWrite);
        end
        vectors++;
        if (PCWrite !== 1'b1) begin
            miscompares++; $display("FAIL reset_pcwrite_nextpc: got %b expected 1", PCWrite);
        end
        NextPC  = 1'b0;
        IRWrite = 1'b1;
        tick();
        tick();
        vectors++;
        if (PCWrite !== 1'b0 || CondEx !== 1'b0) begin
            miscompares++; $display("FAIL reset_held: got PCWrite=%b CondEx=%b expected 0/0", PCWrite, CondEx);
        end
        idle_inputs();
        reset = 1'b0;
        RegW  = 1'b1;
        tick();
        vectors++;
        if (RegWrite !== 1'b0) begin
            miscompares++; $display("FAIL pre_eval_regwrite: got %b expected 0", RegWrite);
        end
        RegW = 1'b0;
    endtask

    task automatic test_al_regwrite();
        do_reset();
        fetch(4'b1110);
        vectors++;
        if (CondEx !== 1'b1) begin
            miscompares++; $display("FAIL al_condex: got %b expected 1", CondEx);
        end
        RegW = 1'b1;
        PCS  = 1'b1;
        #1;
        vectors++;
        if (RegWrite !== 1'b1 || PCWrite !== 1'b1) begin
            miscompares++; $display("FAIL al_writes: got RegWrite=%b PCWrite=%b expected 1/1", RegWrite, PCWrite);
        end
        RegW = 1'b0;
        PCS  = 1'b0;
    endtask

    task automatic test_flag_nz();
        FlagW    = 2'b10;
        ALUFlags = 4'b1011;
        tick();
        FlagW    = 2'b00;
        ALUFlags = 4'b0000;
        vectors++;
        if (Flags !== 4'b1000) begin
            miscompares++; $display("FAIL flagw_nz_only: got %b expected 1000", Flags);
        end
        FlagW    = 2'b01;
        ALUFlags = 4'b0111;
        tick();
        FlagW    = 2'b00;
        vectors++;
        if (Flags !== 4'b1011) begin
            miscompares++; $display("FAIL flagw_cv_only: got %b expected 1011", Flags);
        end
    endtask

    task automatic test_ne_gating();
        set_flags(4'b0100);
        vectors++;
        if (Flags !== 4'b0100) begin
            miscompares++; $display("FAIL set_z_flag: got %b expected 0100", Flags);
        end
        fetch(4'b0001);
        vectors++;
        if (CondEx !== 1'b0) begin
            miscompares++; $display("FAIL ne_condex: got %b expected 0", CondEx);
        end
        MemW = 1'b1;
        PCS  = 1'b1;
        RegW = 1'b1;
        #1;
        vectors++;
        if (MemWrite !== 1'b0 || PCWrite !== 1'b0 || RegWrite !== 1'b0) begin
            miscompares++; $display("FAIL ne_gated: got MemWrite=%b PCWrite=%b RegWrite=%b expected 0/0/0", MemWrite, PCWrite, RegWrite);
        end
        NextPC = 1'b1;
        #1;
        vectors++;
        if (PCWrite !== 1'b1) begin
            miscompares++; $display("FAIL ne_nextpc: got %b expected 1", PCWrite);
        end
        idle_inputs();
    endtask

    task automatic test_eq_noflags();
        do_reset();
        fetch(4'b0000);
        vectors++;
        if (CondEx !== 1'b0) begin
            miscompares++; $display("FAIL eq_condex: got %b expected 0", CondEx);
        end
        FlagW    = 2'b11;
        ALUFlags = 4'b0100;
        tick();
        tick();
        FlagW    = 2'b00;
        vectors++;
        if (Flags !== 4'b0000) begin
            miscompares++; $display("FAIL failed_cond_flagw: got %b expected 0000", Flags);
        end
    endtask

    task automatic test_ge_hold();
        do_reset();
        fetch(4'b1010);
        vectors++;
        if (CondEx !== 1'b1) begin
            miscompares++; $display("FAIL ge_condex: got %b expected 1", CondEx);
        end
        FlagW    = 2'b10;
        ALUFlags = 4'b1000;
        tick();
        FlagW    = 2'b00;
        ALUFlags = 4'b0000;
        tick();
        RegW = 1'b1;
        #1;
        vectors++;
        if (Flags !== 4'b1000 || CondEx !== 1'b1 || RegWrite !== 1'b1) begin
            miscompares++; $display("FAIL ge_hold: got Flags=%b CondEx=%b RegWrite=%b expected 1000/1/1", Flags, CondEx, RegWrite);
        end
        RegW = 1'b0;
    endtask

    task automatic test_eval_ignores_flagw();
        // Flags 1000, CondEx 1 from the GE instruction still in place.
        Cond    = 4'b1110;
        IRWrite = 1'b1;
        tick();
        IRWrite  = 1'b0;
        FlagW    = 2'b11;
        ALUFlags = 4'b0110;
        tick();
        FlagW    = 2'b00;
        ALUFlags = 4'b0000;
        vectors++;
        if (Flags !== 4'b1000) begin
            miscompares++; $display("FAIL eval_flagw_ignored: got %b expected 1000", Flags);
        end
    endtask

    task automatic test_same_cycle_aluflags();
        // Z is clear in the flag register; a Z=1 ALU result during decode must not count.
        Cond     = 4'b0000;
        IRWrite  = 1'b1;
        tick();
        IRWrite  = 1'b0;
        ALUFlags = 4'b0100;
        tick();
        ALUFlags = 4'b0000;
        vectors++;
        if (CondEx !== 1'b0) begin
            miscompares++; $display("FAIL same_cycle_alu: got CondEx=%b expected 0", CondEx);
        end
    endtask

    task automatic test_cond_table();
        logic [8:0] tbl [0:17];
        logic [8:0] row;
        tbl = '{
            {4'b0110, 4'b1000, 1'b0}, {4'b0110, 4'b1001, 1'b1},
            {4'b0010, 4'b1000, 1'b1}, {4'b0010, 4'b1001, 1'b0},
            {4'b0010, 4'b0010, 1'b1}, {4'b0010, 4'b0011, 1'b0},
            {4'b1000, 4'b0100, 1'b1}, {4'b1000, 4'b0101, 1'b0},
            {4'b1001, 4'b0110, 1'b1}, {4'b1001, 4'b0111, 1'b0},
            {4'b1001, 4'b1010, 1'b1}, {4'b1001, 4'b1011, 1'b0},
            {4'b1001, 4'b1100, 1'b1}, {4'b1001, 4'b1101, 1'b0},
            {4'b1000, 4'b1100, 1'b0}, {4'b1000, 4'b1101, 1'b1},
            {4'b1111, 4'b1111, 1'b0}, {4'b0100, 4'b0000, 1'b1}
        };
        for (int i = 0; i < 18; i++) begin
            row = tbl[i];
            set_flags(row[8:5]);
            fetch(row[4:1]);
            vectors++;
            if (CondEx !== row[0]) begin
                miscompares++; $display("FAIL cond_table[%0d] flags=%b cond=%b: got %b expected %b", i, row[8:5], row[4:1], CondEx, row[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_flags(4'b1111);
        Cond    = 4'b1110;
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        RegW    = 1'b1;
        #1;
        vectors++;
        if (Flags !== 4'b1111 || RegWrite !== 1'b1) begin
            miscompares++; $display("FAIL pre_reset_state: got Flags=%b RegWrite=%b expected 1111/1", Flags, RegWrite);
        end
        FlagW    = 2'b11;
        ALUFlags = 4'b0101;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (Flags !== 4'b0000 || CondEx !== 1'b0 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin
            miscompares++; $display("FAIL async_reset: got Flags=%b CondEx=%b RegWrite=%b PCWrite=%b expected 0000/0/0/0", Flags, CondEx, RegWrite, PCWrite);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (Flags !== 4'b0000 || CondEx !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_discard: got Flags=%b CondEx=%b expected 0000/0", Flags, CondEx);
        end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        Cond        = 4'b0000;
        idle_inputs();
        test_reset();
        test_al_regwrite();
        test_flag_nz();
        test_ne_gating();
        test_eq_noflags();
        test_ge_hold();
        test_eval_ignores_flagw();
        test_same_cycle_aluflags();
        test_cond_table();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_condlogic
`default_nettype wire
